// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - MDU op encodings as driven on mult_div_unit.op
//   - controller state encoding
//   - default datapath width and iteration count
package cpu_defs_pkg;

  localparam int MDU_WIDTH = 32;
  // One partial-product / quotient bit per CALC cycle.
  localparam int ITER = MDU_WIDTH;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate.
//   a   : input value
//   neg : 1 -> y = -a, 0 -> y = a
//   y   : result
// Used both to take operand magnitudes at issue (neg = signed op & sign bit)
// and to restore result signs at FIX.
module mdu_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//   clk, rst_n : rising-edge clock, async active-low reset
//   start, op  : issue strobe and op code (sampled only in IDLE)
//   rs_data    : multiplicand / dividend / move source
//   rt_data    : multiplier / divisor
//   busy       : iterative op in flight (IDLE excluded)
//   done       : one-cycle pulse after HI/LO take a new MULT/DIV result
//   hi, lo     : HI / LO registers
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO complete here in one cycle
// CALC  | WIDTH shift-add / restoring-divide iterations on magnitudes
// FIX   | sign correction, HI/LO write, done pulse
module mult_div_unit
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  mdu_state_e         state;
  logic [CW-1:0]      cnt;
  // Multiply: {upper accumulator, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd_b;
  logic               is_div;
  logic               sign_q;
  logic               sign_r;
  logic               div_zero;

  logic               op_mul;
  logic               op_div;
  logic               op_signed;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign op_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
  assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_abs_neg #(.W(WIDTH)) u_rs_abs (
    .a   (rs_data),
    .neg (op_signed & rs_data[WIDTH-1]),
    .y   (rs_abs)
  );

  mdu_abs_neg #(.W(WIDTH)) u_rt_abs (
    .a   (rt_data),
    .neg (op_signed & rt_data[WIDTH-1]),
    .y   (rt_abs)
  );

  mdu_abs_neg #(.W(2*WIDTH)) u_prod_fix (
    .a   (acc),
    .neg (sign_q),
    .y   (prod_fixed)
  );

  // A zero divisor yields an all-ones quotient regardless of operand signs,
  // so its sign correction is suppressed. The remainder path still negates,
  // which restores the original dividend into HI.
  mdu_abs_neg #(.W(WIDTH)) u_quo_fix (
    .a   (acc[WIDTH-1:0]),
    .neg (sign_q & ~div_zero),
    .y   (quo_fixed)
  );

  mdu_abs_neg #(.W(WIDTH)) u_rem_fix (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .neg (sign_r),
    .y   (rem_fixed)
  );

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring step: the partial remainder stays below the divisor, so the
  // shifted value fits WIDTH+1 bits and bit WIDTH of the difference is the
  // borrow. With a zero divisor the remainder only ever holds leading
  // dividend bits, so every step sets a quotient bit and HI ends as the
  // dividend magnitude.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    div_next  = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_mul) begin
              state    <= CALC;
              cnt      <= CNT_LOAD;
              acc      <= {{WIDTH{1'b0}}, rt_abs};
              opnd_b   <= rs_abs;
              is_div   <= 1'b0;
              sign_q   <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              sign_r   <= 1'b0;
              div_zero <= 1'b0;
            end else if (op_div) begin
              state    <= CALC;
              cnt      <= CNT_LOAD;
              acc      <= {{WIDTH{1'b0}}, rs_abs};
              opnd_b   <= rt_abs;
              is_div   <= 1'b1;
              sign_q   <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              sign_r   <= op_signed & rs_data[WIDTH-1];
              div_zero <= (rt_data == '0);
            end else if (op == MDU_MTHI) begin
              hi <= rs_data;
            end else if (op == MDU_MTLO) begin
              lo <= rs_data;
            end
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end else begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue at the next edge, then follow busy until it drops; expects 33 busy
  // cycles, a done pulse right after, and the given HI/LO.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles;
    logic early_done;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; rs_data = '0; rt_data = '0;
    cycles = 0;
    early_done = 1'b0;
    while (busy && cycles < 100) begin
      cycles++;
      if (done) early_done = 1'b1;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 32'(cycles), 32'd33);
    check({name, " done_while_busy"}, {31'b0, early_done}, 32'd0);
    check({name, " done"}, {31'b0, done}, 32'd1);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({name, " done_clear"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int saw_done;
    n_tests = 0;
    n_fail  = 0;
    saw_done = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    rs_data = '0;
    rt_data = '0;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd3, 32'h00000032, 32'h00000007, 32'h00000001, 32'h00000007};
    vecs[6]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[7]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[12] = '{3'd0, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    rst_n = 1'b1;

    // MTHI in IDLE: single cycle, no busy, no done
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_data = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", hi, 32'h12345678);
    check("mthi busy", {31'b0, busy}, 32'd0);
    check("mthi done", {31'b0, done}, 32'd0);

    // op 6 with start: nothing changes
    start = 1'b1; op = 3'd6; rs_data = 32'hAAAA5555;
    @(negedge clk);
    start = 1'b0;
    check("op6 hi", hi, 32'h12345678);
    check("op6 lo", lo, 32'd0);
    check("op6 busy", {31'b0, busy}, 32'd0);

    // MULTU 3*4 with an MTLO issued mid-flight that must be ignored
    start = 1'b1; op = 3'd1; rs_data = 32'd3; rt_data = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd5; rs_data = 32'h0000DEAD;
    @(negedge clk);
    start = 1'b0;
    check("ignored mtlo lo", lo, 32'd0);
    check("ignored mtlo hi", hi, 32'h12345678);
    begin
      int k;
      k = 0;
      while (!done && k < 100) begin k++; @(negedge clk); end
      check("mul34 done seen", {31'b0, done}, 32'd1);
    end
    check("mul34 lo", lo, 32'h0000000C);
    check("mul34 hi", hi, 32'h00000000);
    check("mul34 busy", {31'b0, busy}, 32'd0);

    // Table-driven MULT/DIV vectors
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
    end

    // Reset mid-operation aborts: busy/HI/LO clear at once, no done afterwards
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_data = 32'd50; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort busy before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("abort no done", 32'(saw_done), 32'd0);
    run_op("divu50_7 after reset", 3'd3, 32'd50, 32'd7, 32'd1, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
